tb_run_ctrl: RTL and testbench

TB_RUN_CTRL -- requirements
Module: tb_run_ctrl

---
 rtl/tb_run_pkg.sv | 18 +
 rtl/tb_stall_cnt.sv | 31 +++
 rtl/tb_run_ctrl.sv | 121 ++++++++++++
 tb/tb_tb_run_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/tb_run_pkg.sv
// Shared types for the test-bench run controller: FSM state encoding.
package tb_run_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RESET = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_HALT  = 3'd3;
  localparam logic [2:0] ST_FAIL  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    RESET = ST_RESET,
    RUN   = ST_RUN,
    HALT  = ST_HALT,
    FAIL  = ST_FAIL
  } run_state_t;

endpackage

// File: rtl/tb_stall_cnt.sv
// One progress-watchdog channel: counts enabled cycles since the last progress
// pulse and flags when that count reaches a non-zero limit.
module tb_stall_cnt #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 progress,
  input  logic [CNT_WIDTH-1:0] limit,
  output logic                 hit
);

  logic [CNT_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      if (progress) begin
        count <= '0;
      end else if (count != '1) begin
        count <= count + CNT_WIDTH'(1);
      end
    end
  end

  assign hit = (limit != '0) && (count == limit);

endmodule

// File: rtl/tb_run_ctrl.sv
// Run controller: sequences CPU reset, bounded run with cycle budget and
// per-channel progress watchdogs, and reports a clean halt or a failure.
module tb_run_ctrl
  import tb_run_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int NR_CHAN    = 2,
  parameter int RST_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop_req,
  input  logic [ADDR_WIDTH-1:0] cfg_rst_addr,
  input  logic [CNT_WIDTH-1:0]  cfg_max_cycles,
  input  logic                  cfg_run_forever,
  input  logic                  cfg_dbg_on_rst,
  input  logic [CNT_WIDTH-1:0]  cfg_stall_limit,
  input  logic [NR_CHAN-1:0]    progress,
  output logic                  cpu_rst,
  output logic [ADDR_WIDTH-3:0] rst_addr,
  output logic                  dbg_on_rst,
  output logic [CNT_WIDTH-1:0]  cycle_cnt,
  output run_state_t            state,
  output logic                  timeout,
  output logic [NR_CHAN-1:0]    stall_err,
  output logic                  done
);

  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  logic [HOLD_W-1:0]    hold_cnt;
  logic [CNT_WIDTH-1:0] max_cycles;
  logic [CNT_WIDTH-1:0] stall_limit;
  logic                 run_forever;
  logic [NR_CHAN-1:0]   stall_hit;
  logic                 accept;
  logic                 in_run;
  logic                 timeout_hit;

  assign accept      = start && (state == IDLE || state == HALT || state == FAIL);
  assign in_run      = (state == RUN);
  assign timeout_hit = in_run && !run_forever && (cycle_cnt == max_cycles);

  generate
    for (genvar ch = 0; ch < NR_CHAN; ch++) begin : g_chan
      tb_stall_cnt #(
        .CNT_WIDTH(CNT_WIDTH)
      ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .enable  (in_run),
        .progress(progress[ch]),
        .limit   (stall_limit),
        .hit     (stall_hit[ch])
      );
    end
  endgenerate

  // The cycle that leaves RUN does not advance cycle_cnt, so a budget
  // timeout leaves the counter showing exactly the budget.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cpu_rst     <= 1'b1;
      done        <= 1'b0;
      cycle_cnt   <= '0;
      timeout     <= 1'b0;
      stall_err   <= '0;
      rst_addr    <= '0;
      dbg_on_rst  <= 1'b0;
      max_cycles  <= '0;
      stall_limit <= '0;
      run_forever <= 1'b0;
      hold_cnt    <= '0;
    end else if (accept) begin
      state       <= RESET;
      cpu_rst     <= 1'b1;
      done        <= 1'b0;
      cycle_cnt   <= '0;
      timeout     <= 1'b0;
      stall_err   <= '0;
      rst_addr    <= cfg_rst_addr[ADDR_WIDTH-1:2];
      dbg_on_rst  <= cfg_dbg_on_rst;
      max_cycles  <= cfg_max_cycles;
      stall_limit <= cfg_stall_limit;
      run_forever <= cfg_run_forever;
      hold_cnt    <= '0;
    end else begin
      case (state)
        RESET: begin
          if (hold_cnt == HOLD_LAST) begin
            state   <= RUN;
            cpu_rst <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        RUN: begin
          if (stop_req) begin
            state <= HALT;
            done  <= 1'b1;
          end else if (timeout_hit || (stall_hit != '0)) begin
            state     <= FAIL;
            done      <= 1'b1;
            timeout   <= timeout_hit;
            stall_err <= stall_hit;
          end else if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Self-checking bench for tb_run_ctrl: directed scenarios plus randomized runs
// predicted by a run-outcome model built from the run rules.
module tb_tb_run_ctrl;
  import tb_run_pkg::*;

  localparam int AW       = 32;
  localparam int CW       = 32;
  localparam int NC       = 2;
  localparam int RST_HOLD = 4;
  localparam int MAXK     = 200;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stop_req = 1'b0;
  logic [AW-1:0] cfg_rst_addr = '0;
  logic [CW-1:0] cfg_max_cycles = '0;
  logic          cfg_run_forever = 1'b0;
  logic          cfg_dbg_on_rst = 1'b0;
  logic [CW-1:0] cfg_stall_limit = '0;
  logic [NC-1:0] progress = '0;
  logic          cpu_rst;
  logic [AW-3:0] rst_addr;
  logic          dbg_on_rst;
  logic [CW-1:0] cycle_cnt;
  run_state_t    state;
  logic          timeout;
  logic [NC-1:0] stall_err;
  logic          done;

  int checks = 0;
  int errors = 0;

  // Per-RUN-cycle stimulus schedule shared by the model and the driver.
  logic [NC-1:0] prog_s [MAXK];
  logic          stop_s [MAXK];
  logic          start_s[MAXK];

  tb_run_ctrl #(
    .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .NR_CHAN(NC), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop_req(stop_req),
    .cfg_rst_addr(cfg_rst_addr), .cfg_max_cycles(cfg_max_cycles),
    .cfg_run_forever(cfg_run_forever), .cfg_dbg_on_rst(cfg_dbg_on_rst),
    .cfg_stall_limit(cfg_stall_limit), .progress(progress),
    .cpu_rst(cpu_rst), .rst_addr(rst_addr), .dbg_on_rst(dbg_on_rst),
    .cycle_cnt(cycle_cnt), .state(state), .timeout(timeout),
    .stall_err(stall_err), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic sp, input logic [NC-1:0] pg);
    start    = st;
    stop_req = sp;
    progress = pg;
    @(negedge clk);
  endtask

  task automatic clearSched();
    for (int k = 0; k < MAXK; k++) begin
      prog_s[k]  = '0;
      stop_s[k]  = 1'b0;
      start_s[k] = 1'b0;
    end
    stop_s[MAXK-1] = 1'b1;
  endtask

  // Walks RUN cycles k = 0,1,..: cycle_cnt reads k, a channel's idle length is
  // the distance back to its last progress pulse; first ending rule wins.
  task automatic predict(input logic [CW-1:0] max_c, input logic fe, input logic [CW-1:0] lim,
                         output int end_k, output run_state_t st, output logic to,
                         output logic [NC-1:0] err);
    int last[NC];
    logic [NC-1:0] hit;
    logic t;
    for (int ch = 0; ch < NC; ch++) last[ch] = -1;
    end_k = MAXK - 1; st = HALT; to = 1'b0; err = '0;
    for (int k = 0; k < MAXK; k++) begin
      hit = '0;
      for (int ch = 0; ch < NC; ch++)
        if (lim != 0 && longint'(k - last[ch] - 1) == longint'(lim)) hit[ch] = 1'b1;
      t = !fe && (longint'(k) == longint'(max_c));
      if (stop_s[k]) begin
        end_k = k; st = HALT; return;
      end
      if (t || hit != '0) begin
        end_k = k; st = FAIL; to = t; err = hit; return;
      end
      for (int ch = 0; ch < NC; ch++)
        if (prog_s[k][ch]) last[ch] = k;
    end
  endtask

  task automatic doRun(input string name, input logic [AW-1:0] addr, input logic [CW-1:0] max_c,
                       input logic fe, input logic dbg, input logic [CW-1:0] lim, input int rst_at);
    int end_k;
    run_state_t exp_st;
    logic exp_to;
    logic [NC-1:0] exp_err;
    logic [AW-1:0] a;
    logic [AW-3:0] exp_addr;
    a = addr;
    exp_addr = a[AW-1:2];
    predict(max_c, fe, lim, end_k, exp_st, exp_to, exp_err);

    cfg_rst_addr = addr; cfg_max_cycles = max_c; cfg_run_forever = fe;
    cfg_dbg_on_rst = dbg; cfg_stall_limit = lim;
    applyStimulus(1'b1, 1'b0, '0);
    for (int i = 0; i < RST_HOLD; i++) begin
      checkOutput({name, " reset state"}, 64'(state), 64'(RESET));
      checkOutput({name, " reset cpu_rst"}, 64'(cpu_rst), 64'd1);
      if (i == 0) begin
        checkOutput({name, " start clears cnt"}, 64'(cycle_cnt), 64'd0);
        checkOutput({name, " start clears flags"}, {62'd0, timeout, done}, 64'd0);
        checkOutput({name, " start clears stall_err"}, 64'(stall_err), 64'd0);
      end
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), NC'($urandom_range(0, 3)));
    end
    checkOutput({name, " run cpu_rst"}, 64'(cpu_rst), 64'd0);
    checkOutput({name, " rst_addr"}, 64'(rst_addr), 64'(exp_addr));
    checkOutput({name, " dbg_on_rst"}, 64'(dbg_on_rst), 64'(dbg));

    for (int k = 0; k <= end_k; k++) begin
      checkOutput({name, " run state"}, 64'(state), 64'(RUN));
      checkOutput({name, " run cycle_cnt"}, 64'(cycle_cnt), 64'(k));
      if (k == rst_at) begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, '0);
        rst = 1'b0;
        checkOutput({name, " rst state"}, 64'(state), 64'(IDLE));
        checkOutput({name, " rst cpu_rst"}, 64'(cpu_rst), 64'd1);
        checkOutput({name, " rst cnt"}, 64'(cycle_cnt), 64'd0);
        checkOutput({name, " rst flags"}, {61'd0, timeout, done, dbg_on_rst}, 64'd0);
        checkOutput({name, " rst stall_err"}, 64'(stall_err), 64'd0);
        checkOutput({name, " rst rst_addr"}, 64'(rst_addr), 64'd0);
        return;
      end
      applyStimulus(start_s[k], stop_s[k], prog_s[k]);
    end
    start = 1'b0; stop_req = 1'b0; progress = '0;

    checkOutput({name, " end state"}, 64'(state), 64'(exp_st));
    checkOutput({name, " end done"}, 64'(done), 64'd1);
    checkOutput({name, " end timeout"}, 64'(timeout), 64'(exp_to));
    checkOutput({name, " end stall_err"}, 64'(stall_err), 64'(exp_err));
    checkOutput({name, " end cycle_cnt"}, 64'(cycle_cnt), 64'(end_k));
    checkOutput({name, " end cpu_rst"}, 64'(cpu_rst), 64'd0);
    applyStimulus(1'b0, 1'b1, '1);
    checkOutput({name, " hold state"}, 64'(state), 64'(exp_st));
    checkOutput({name, " hold cycle_cnt"}, 64'(cycle_cnt), 64'(end_k));
    checkOutput({name, " hold rst_addr"}, 64'(rst_addr), 64'(exp_addr));
  endtask

  initial begin
    int dens;
    $display("[TB] starting tb_run_ctrl bench");
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    rst = 1'b0;
    checkOutput("por state", 64'(state), 64'(IDLE));
    checkOutput("por cpu_rst", 64'(cpu_rst), 64'd1);
    checkOutput("por cnt", 64'(cycle_cnt), 64'd0);
    checkOutput("por flags", {61'd0, timeout, done, dbg_on_rst}, 64'd0);
    checkOutput("por stall_err", 64'(stall_err), 64'd0);
    checkOutput("por rst_addr", 64'(rst_addr), 64'd0);

    clearSched();
    doRun("budget", 32'h1000, 32'd10, 1'b0, 1'b1, 32'd0, -1);

    clearSched();
    stop_s[50] = 1'b1;
    doRun("forever_stop", 32'h2004, 32'd10, 1'b1, 1'b0, 32'd0, -1);

    clearSched();
    for (int k = 0; k < MAXK; k++) prog_s[k][0] = (k % 3 == 2);
    doRun("stall", 32'h3000, 32'd100, 1'b0, 1'b0, 32'd5, -1);

    clearSched();
    stop_s[10] = 1'b1;
    doRun("stop_vs_budget", 32'h4000, 32'd10, 1'b0, 1'b1, 32'd0, -1);

    clearSched();
    doRun("mid_rst", 32'h5000, 32'd100, 1'b1, 1'b1, 32'd0, 20);
    clearSched();
    doRun("after_rst", 32'h6008, 32'd15, 1'b0, 1'b0, 32'd0, -1);

    for (int r = 0; r < 10; r++) begin
      clearSched();
      dens = $urandom_range(1, 6);
      for (int k = 0; k < MAXK - 1; k++) begin
        for (int ch = 0; ch < NC; ch++) prog_s[k][ch] = ($urandom_range(0, dens - 1) == 0);
        stop_s[k]  = ($urandom_range(0, 59) == 0);
        start_s[k] = ($urandom_range(0, 19) == 0);
      end
      doRun("random", AW'($urandom), CW'($urandom_range(3, 80)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? CW'(0) : CW'($urandom_range(2, 12)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
